// File: rtl/p_hit_pkg.sv
// Shared types for the p_hit arbiter: Q16.16 word/vector types and the arbiter state encoding.
package p_hit_pkg;

  localparam int D_BITS = 32;
  localparam int Q_BITS = 16;

  typedef logic signed [D_BITS-1:0] word_t;
  typedef word_t [2:0] vec3_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/p_hit_tag_fifo.sv
// Synchronous FIFO of requester tags for rays in flight inside p_hit; head is the oldest ray's owner.
module p_hit_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_tag_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push_i && (cnt_q != (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i && (cnt_q != '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  // Tag storage: payload only, validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_tag_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/p_hit_arbiter.sv
// Round-robin sharing of one p_hit unit among N_REQ ray requesters, with in-order tagged
// result return, a drain handshake and a sticky orphan-result error.
module p_hit_arbiter
  import p_hit_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16,
  localparam int TW       = $clog2(N_REQ),
  localparam int CW       = $clog2(TAG_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_empty,
  output logic [N_REQ-1:0] req_rd_en,
  input  vec3_t            req_tri_normal [N_REQ],
  input  vec3_t            req_v0         [N_REQ],
  input  vec3_t            req_origin     [N_REQ],
  input  vec3_t            req_dir        [N_REQ],
  input  logic             ph_full,
  output logic             ph_wr_en,
  output vec3_t            ph_tri_normal,
  output vec3_t            ph_v0,
  output vec3_t            ph_origin,
  output vec3_t            ph_dir,
  input  logic             ph_empty,
  output logic             ph_rd_en,
  input  vec3_t            ph_p_hit,
  input  vec3_t            ph_v0_out,
  input  logic [N_REQ-1:0] rsp_full,
  output logic [N_REQ-1:0] rsp_wr_en,
  output vec3_t            rsp_p_hit,
  output vec3_t            rsp_v0,
  input  logic             drain_req,
  output logic             drain_done,
  output logic             err_orphan
);

  arb_state_t    state_q, state_d;
  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  vec3_t         tri_q, v0_q, origin_q, dir_q;
  logic          err_q;
  logic          issue_en_s;
  logic          grant_valid_s;
  logic [TW-1:0] grant_idx_s;
  logic          issue_s;
  logic [TW-1:0] head_tag_s;
  logic [CW-1:0] tag_cnt_s;
  logic          pop_s;
  int            idx_v;

  p_hit_tag_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (issue_s),
    .push_tag_i (grant_idx_s),
    .pop_i      (pop_s),
    .head_o     (head_tag_s),
    .count_o    (tag_cnt_s)
  );

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    idx_v         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_v = int'(rr_ptr_q) + k;
      if (idx_v >= N_REQ) begin
        idx_v = idx_v - N_REQ;
      end else begin
        idx_v = idx_v;
      end
      if (!grant_valid_s && !req_empty[idx_v]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = TW'(idx_v);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // A full tag FIFO blocks issue even if a result pops this cycle; the slot frees next cycle.
  assign issue_s  = issue_en_s && !ph_full && (tag_cnt_s < CW'(TAG_DEPTH)) && grant_valid_s;
  assign rr_ptr_d = issue_s ? grant_idx_s : rr_ptr_q;
  assign pop_s    = !ph_empty && (tag_cnt_s != '0) && !rsp_full[head_tag_s];

  assign req_rd_en     = issue_s ? (N_REQ'(1) << grant_idx_s) : '0;
  assign ph_wr_en      = issue_s;
  assign ph_tri_normal = issue_s ? req_tri_normal[grant_idx_s] : tri_q;
  assign ph_v0         = issue_s ? req_v0[grant_idx_s]         : v0_q;
  assign ph_origin     = issue_s ? req_origin[grant_idx_s]     : origin_q;
  assign ph_dir        = issue_s ? req_dir[grant_idx_s]        : dir_q;

  assign ph_rd_en   = pop_s;
  assign rsp_wr_en  = pop_s ? (N_REQ'(1) << head_tag_s) : '0;
  assign rsp_p_hit  = ph_p_hit;
  assign rsp_v0     = ph_v0_out;
  assign err_orphan = err_q;

  // Round-robin pointer, last issued bundle and sticky orphan flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= TW'(N_REQ - 1);
      tri_q    <= '0;
      v0_q     <= '0;
      origin_q <= '0;
      dir_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (issue_s) begin
        tri_q    <= req_tri_normal[grant_idx_s];
        v0_q     <= req_v0[grant_idx_s];
        origin_q <= req_origin[grant_idx_s];
        dir_q    <= req_dir[grant_idx_s];
      end
      err_q <= err_q | (!ph_empty && (tag_cnt_s == '0));
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; DRAIN completes on the cycle the last outstanding tag pops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
        else           state_d = RUN;
      end
      DRAIN: begin
        if (!drain_req)                                             state_d = RUN;
        else if ((tag_cnt_s == '0) || ((tag_cnt_s == CW'(1)) && pop_s)) state_d = DONE;
        else                                                        state_d = DRAIN;
      end
      DONE: begin
        if (!drain_req) state_d = RUN;
        else            state_d = DONE;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    issue_en_s = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      RUN:     issue_en_s = 1'b1;
      DRAIN:   drain_done = 1'b0;
      DONE:    drain_done = 1'b1;
      default: issue_en_s = 1'b0;
    endcase
  end

endmodule
